ex2_row_sched: RTL and testbench

Row scheduler for the E[x²] statistics engine (`Ex2_Unit`) in the AILayerNorm datapath. It accepts a stalling stream of 9-bit samples and buffers them into 8-sample rows. Each complete row is replayed to the engine as one start pulse followed by 8 back-to-back samples, which the engine requires because it cannot stall. The block captures the engine's 32-bit result and presents it on a valid/ready output with a completion watchdog.

---
 rtl/ex2_row_sched.sv | 109 ++++++++++
 tb/tb_ex2_row_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex2_row_sched.sv
// ex2_row_sched: buffers 9-bit samples into 8-sample rows and replays each row to the E[x^2] engine.
// EX2_PINGPONG_EN selects two row banks instead of one.
module ex2_row_sched #(
  parameter int         N       = 8,
  parameter logic [7:0] INV_N   = 8'd32,
  parameter int         TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [8:0]  i_in_x,
  input  logic [1:0]  i_in_alpha,
  output logic        o_ex2_valid,
  output logic [8:0]  o_ex2_x,
  output logic [1:0]  o_ex2_alpha,
  output logic [7:0]  o_ex2_inv_n,
  input  logic        i_ex2_done,
  input  logic [31:0] i_ex2,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [31:0] o_res,
  output logic        o_busy,
  output logic        o_err
);
`ifdef EX2_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, STREAM, WAIT, OUT} state_t;
  state_t          state_q, state_d;
  logic [8:0]      buf_q [NB][N];
  logic [1:0]      alpha_q [NB];
  logic [NB-1:0]   full_q;
  logic            fill_q, rd_q;
  logic [IW-1:0]   wr_idx_q, rd_idx_q;
  logic [TW-1:0]   wait_q;
  logic [31:0]     res_q;
  logic            err_q;
  logic            hs, last_rd, timeout;
  assign hs      = i_in_valid && o_in_ready;
  assign last_rd = state_q == STREAM && rd_idx_q == IW'(N - 1);
  assign timeout = state_q == WAIT && !i_ex2_done && wait_q == TW'(TIMEOUT - 1);
`ifdef EX2_PINGPONG_EN
  assign o_in_ready = !full_q[fill_q];
`else
  // single bank: the row stays owned by the engine until the result leaves
  assign o_in_ready = !full_q[fill_q] && state_q != WAIT && state_q != OUT;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = full_q[rd_q] ? LAUNCH : IDLE;
      LAUNCH:  state_d = STREAM;
      STREAM:  state_d = last_rd ? WAIT : STREAM;
      WAIT:    state_d = i_ex2_done ? OUT : (timeout ? IDLE : WAIT);
      OUT:     state_d = i_res_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      full_q   <= '0;
      fill_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      wait_q   <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      alpha_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      rd_idx_q <= state_q == STREAM ? rd_idx_q + 1'b1 : '0;
      wait_q   <= state_q == WAIT ? wait_q + 1'b1 : '0;
      if (last_rd) begin
        full_q[rd_q] <= 1'b0;
`ifdef EX2_PINGPONG_EN
        rd_q <= ~rd_q;
`endif
      end
      if (hs) begin
        buf_q[fill_q][wr_idx_q] <= i_in_x;
        wr_idx_q <= wr_idx_q + 1'b1;
        if (wr_idx_q == '0) alpha_q[fill_q] <= i_in_alpha;
        if (wr_idx_q == IW'(N - 1)) begin
          full_q[fill_q] <= 1'b1;
`ifdef EX2_PINGPONG_EN
          fill_q <= ~fill_q;
`endif
        end
      end
      if (state_q == WAIT && i_ex2_done) res_q <= i_ex2;
      if (timeout) err_q <= 1'b1;
    end
  end
  assign o_ex2_valid = state_q == LAUNCH;
  assign o_ex2_x     = state_q == STREAM ? buf_q[rd_q][rd_idx_q] : '0;
  assign o_ex2_alpha = (state_q == LAUNCH || state_q == STREAM) ? alpha_q[rd_q] : '0;
  assign o_ex2_inv_n = INV_N;
  assign o_res_valid = state_q == OUT;
  assign o_res       = res_q;
  assign o_busy      = state_q != IDLE;
  assign o_err       = err_q;
endmodule

// File: tb/tb_ex2_row_sched.sv
// tb_ex2_row_sched: directed checks of ex2_row_sched against a behavioural E[x^2] engine.
`define CHK(tag, obs, exp) \
  checks++; \
  assert ((obs) === (exp)) else begin \
    failures++; \
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
  end
module tb_ex2_row_sched;
  logic        clk = 0;
  logic        i_rst = 1, i_in_valid = 0, i_res_ready = 1;
  logic [8:0]  i_in_x = 0;
  logic [1:0]  i_in_alpha = 0;
  logic        o_in_ready, o_ex2_valid, o_res_valid, o_busy, o_err, i_ex2_done;
  logic [8:0]  o_ex2_x;
  logic [1:0]  o_ex2_alpha;
  logic [7:0]  o_ex2_inv_n;
  logic [31:0] i_ex2, o_res;
  int checks = 0, failures = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ex2_row_sched dut (
    .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_x(i_in_x), .i_in_alpha(i_in_alpha), .o_ex2_valid(o_ex2_valid), .o_ex2_x(o_ex2_x),
    .o_ex2_alpha(o_ex2_alpha), .o_ex2_inv_n(o_ex2_inv_n), .i_ex2_done(i_ex2_done), .i_ex2(i_ex2),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res(o_res), .o_busy(o_busy), .o_err(o_err)
  );
  // engine: mean of (x<<alpha)^2 scaled by INV_N, result = (sum * 32) >> 12, done one cycle after sample 8
  logic        eng_kill = 0, stray_done = 0, eng_done = 0;
  logic [1:0]  eng_a = 0;
  logic [31:0] eng_res = 0;
  longint      eng_acc = 0;
  int          eng_cnt = 0;
  function automatic longint sq(input logic [8:0] x, input logic [1:0] a);
    longint s;
    s = longint'(x) << a;
    return s * s;
  endfunction
  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (i_rst) eng_cnt <= 0;
    else if (o_ex2_valid) begin
      eng_cnt <= 8;
      eng_acc <= 0;
      eng_a   <= o_ex2_alpha;
    end else if (eng_cnt > 0) begin
      eng_acc <= eng_acc + sq(o_ex2_x, eng_a);
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done <= !eng_kill;
        eng_res  <= 32'(((eng_acc + sq(o_ex2_x, eng_a)) * 32) >> 12);
      end
    end
  end
  assign i_ex2_done = eng_done | stray_done;
  assign i_ex2      = eng_done ? eng_res : 32'hDEAD_BEEF;
  // monitors
  int ev_cnt = 0, sp = -1, rv_n = 0, rv_t = 0, xfer_n = 0;
  int rv_q[$];
  logic [8:0]  strm [8];
  logic [1:0]  ev_alpha = 0;
  logic [31:0] rv_res = 0;
  logic        rv_prev = 0;
  always @(negedge clk) begin
    if (o_ex2_valid) begin
      ev_cnt   <= ev_cnt + 1;
      ev_alpha <= o_ex2_alpha;
      sp       <= 0;
    end else if (sp >= 0 && sp < 8) begin
      strm[sp] <= o_ex2_x;
      sp       <= sp + 1;
    end
    if (o_res_valid && !rv_prev) begin
      rv_n   <= rv_n + 1;
      rv_t   <= cyc;
      rv_res <= o_res;
      rv_q.push_back(cyc);
    end
    rv_prev <= o_res_valid;
  end
  always @(posedge clk) if (o_res_valid && i_res_ready) xfer_n <= xfer_n + 1;
  task automatic send_row(input logic [8:0] x, input logic [1:0] a, input bit gap, output int t);
    int n;
    bit ph;
    n = 0; ph = 0; t = -1;
    for (int g = 0; g < 300 && n < 8; g++) begin
      @(negedge clk);
      if (gap && ph) i_in_valid = 0;
      else begin
        i_in_valid = 1;
        i_in_x     = x;
        i_in_alpha = (n == 0) ? a : 2'd3;
        if (o_in_ready) begin
          n++;
          t = cyc;
        end
      end
      ph = !ph;
    end
    @(negedge clk);
    i_in_valid = 0;
    i_in_x     = 0;
    `CHK("row_accepted", n, 8)
  endtask
  task automatic wait_rv(input int n0);
    for (int g = 0; g < 80 && rv_n == n0; g++) @(negedge clk);
    @(negedge clk);
    checks++;
    assert (rv_n != n0) else begin
      failures++;
      $error("FAIL res_valid_timeout observed=%0d expected=%0d", rv_n, n0 + 1);
    end
  endtask
  int t, n0, e0, x0;
  bit stable;
  initial begin
    repeat (2) @(negedge clk);
    `CHK("rst_in_ready", o_in_ready, 1'b1)
    `CHK("rst_ex2_valid", o_ex2_valid, 1'b0)
    `CHK("rst_ex2_x", o_ex2_x, 9'd0)
    `CHK("rst_ex2_alpha", o_ex2_alpha, 2'd0)
    `CHK("rst_inv_n", o_ex2_inv_n, 8'd32)
    `CHK("rst_res_valid", o_res_valid, 1'b0)
    `CHK("rst_res", o_res, 32'd0)
    `CHK("rst_busy", o_busy, 1'b0)
    `CHK("rst_err", o_err, 1'b0)
    i_rst = 0;
    // single row of 4s: (8*16*32)>>12 = 1
    n0 = rv_n; e0 = ev_cnt;
    send_row(9'd4, 2'd0, 0, t);
    wait_rv(n0);
    `CHK("r1_res", rv_res, 32'd1)
    `CHK("r1_latency", rv_t - t, 12)
    `CHK("r1_start_pulses", ev_cnt - e0, 1)
    `CHK("r1_stream0", strm[0], 9'd4)
    `CHK("r1_stream7", strm[7], 9'd4)
    // gapped row of 64s, alpha 1 on element 0 only: (8*128^2*32)>>12 = 1024
    n0 = rv_n;
    send_row(9'd64, 2'd1, 1, t);
    wait_rv(n0);
    `CHK("r2_res", rv_res, 32'd1024)
    `CHK("r2_latency", rv_t - t, 12)
    `CHK("r2_alpha", ev_alpha, 2'd1)
    for (int i = 0; i < 8; i++) begin
      `CHK("r2_stream", strm[i], 9'd64)
    end
    // output back-pressure for 20 cycles: (8*100*32)>>12 = 6
    i_res_ready = 0;
    n0 = rv_n; x0 = xfer_n;
    send_row(9'd10, 2'd0, 0, t);
    wait_rv(n0);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i_in_valid = 1;
      if (!(o_res_valid === 1'b1 && o_res === 32'd6 && o_in_ready === 1'b0)) stable = 0;
    end
    i_in_valid = 0;
    `CHK("hold_stable", stable, 1'b1)
    `CHK("hold_no_xfer", xfer_n - x0, 0)
    i_res_ready = 1;
    repeat (3) @(negedge clk);
    `CHK("hold_one_xfer", xfer_n - x0, 1)
    `CHK("hold_released", o_res_valid, 1'b0)
    `CHK("hold_ready_back", o_in_ready, 1'b1)
    // watchdog: WAIT entered at t+11, error flag at t+11+16
    eng_kill = 1;
    n0 = rv_n;
    send_row(9'd5, 2'd0, 0, t);
    for (int g = 0; g < 100 && !o_err; g++) @(negedge clk);
    `CHK("wd_err", o_err, 1'b1)
    `CHK("wd_time", cyc - t, 27)
    `CHK("wd_idle", o_busy, 1'b0)
    `CHK("wd_no_result", rv_n - n0, 0)
    eng_kill = 0;
    @(negedge clk);
    stray_done = 1;
    @(negedge clk);
    stray_done = 0;
    repeat (2) @(negedge clk);
    `CHK("stray_done_ignored", o_res_valid, 1'b0)
    `CHK("stray_done_idle", o_busy, 1'b0)
    // recovery row, alpha 2: (8*32^2*32)>>12 = 64
    n0 = rv_n;
    send_row(9'd8, 2'd2, 0, t);
    wait_rv(n0);
    `CHK("wd_next_res", rv_res, 32'd64)
    `CHK("wd_err_sticky", o_err, 1'b1)
    // reset during STREAM at rd_idx 3
    send_row(9'd4, 2'd0, 0, t);
    for (int g = 0; g < 40 && !o_ex2_valid; g++) @(negedge clk);
    `CHK("rs_launch", o_ex2_valid, 1'b1)
    repeat (4) @(negedge clk);
    `CHK("rs_streaming", o_ex2_x, 9'd4)
    i_rst = 1;
    @(negedge clk);
    i_rst = 0;
    `CHK("rs_in_ready", o_in_ready, 1'b1)
    `CHK("rs_busy", o_busy, 1'b0)
    `CHK("rs_ex2_x", o_ex2_x, 9'd0)
    `CHK("rs_res", o_res, 32'd0)
    `CHK("rs_err", o_err, 1'b0)
    e0 = ev_cnt;
    repeat (6) @(negedge clk);
    `CHK("rs_banks_empty", ev_cnt - e0, 0)
    // (8*4096*32)>>12 = 256
    n0 = rv_n;
    send_row(9'd64, 2'd0, 0, t);
    wait_rv(n0);
    `CHK("rs_next_res", rv_res, 32'd256)
    `CHK("rs_next_latency", rv_t - t, 12)
`ifdef EX2_PINGPONG_EN
    // three rows with continuous input: results 12 cycles apart
    n0 = rv_n;
    rv_q.delete();
    begin
      int n;
      n = 0;
      for (int g = 0; g < 400 && n < 24; g++) begin
        @(negedge clk);
        i_in_valid = 1;
        i_in_x     = 9'd4;
        i_in_alpha = 2'd0;
        if (o_in_ready) n++;
      end
      @(negedge clk);
      i_in_valid = 0;
    end
    for (int g = 0; g < 120 && rv_n < n0 + 3; g++) @(negedge clk);
    `CHK("pp_results", rv_n - n0, 3)
    if (rv_q.size() == 3) begin
      `CHK("pp_gap1", rv_q[1] - rv_q[0], 12)
      `CHK("pp_gap2", rv_q[2] - rv_q[1], 12)
      `CHK("pp_res", rv_res, 32'd1)
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
